// File: rtl/store_rmw.sv
// Store sequencer: word stores issue a single bus write; byte stores read the
// addressed word, insert the byte at lane byte_idx and write the merged word back.
module store_rmw #(
  parameter int WIDTH = 32,
  parameter int AW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_byte,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [1:0]       byte_idx,
  output logic             ready,
  output logic             done,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_wbuf;
  logic [1:0]       r_idx;
  logic             r_byte;
  logic [WIDTH-1:0] w_merged;

  // Read word with the latched byte replacing lane r_idx.
  always_comb begin
    w_merged = mem_rdata;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r_idx == 2'(i)) begin
        w_merged[8*i +: 8] = r_wdata[7:0];
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = is_byte ? S_RD : S_WR;
      S_RD:    if (mem_ack) w_next = S_WR;
      S_WR:    if (mem_ack) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are forced low while reset is high so a pending request drops immediately.
  always_comb begin
    ready     = 1'b0;
    done      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (!reset) begin
      case (r_state)
        S_IDLE: ready = 1'b1;
        S_RD: begin
          mem_rd   = 1'b1;
          mem_addr = r_addr;
        end
        S_WR: begin
          mem_wr    = 1'b1;
          mem_addr  = r_addr;
          mem_wdata = r_byte ? r_wbuf : r_wdata;
        end
        S_DONE:  done = 1'b1;
        default: ready = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wbuf  <= '0;
      r_idx   <= '0;
      r_byte  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && start) begin
        r_addr  <= addr;
        r_wdata <= wdata;
        r_idx   <= byte_idx;
        r_byte  <= is_byte;
      end
      if (r_state == S_RD && mem_ack) begin
        r_wbuf <= w_merged;
      end
    end
  end

endmodule

// File: tb/tb_store_rmw.sv
// Bench for store_rmw: transaction-level expectation queue checked every cycle,
// plus a bus responder with random wait states backed by a small memory.
module tb_store_rmw;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_byte;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  byte_idx;
  logic        ready;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  store_rmw #(.WIDTH(32), .AW(32)) dut (
    .clk(clk), .reset(reset), .start(start), .is_byte(is_byte),
    .addr(addr), .wdata(wdata), .byte_idx(byte_idx),
    .ready(ready), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ready;
    bit          done;
    bit          rd;
    bit          wr;
    bit          commit;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] wlog[$];
  logic [31:0] bus_mem[32];
  logic [31:0] ref_mem[32];
  int          rd_wait = 0;
  int          wr_wait = 0;
  int          checks  = 0;
  int          errors  = 0;

  function automatic exp_t mk(bit r, bit d, bit rd, bit wr, bit c,
                              logic [31:0] a, logic [31:0] w);
    exp_t e;
    e.ready = r; e.done = d; e.rd = rd; e.wr = wr; e.commit = c;
    e.addr = a;  e.wdata = w;
    return e;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [7:0] b, logic [1:0] idx);
    int sh;
    sh = 8 * int'(idx);
    return (old & ~(32'h0000_00FF << sh)) | ({24'h0, b} << sh);
  endfunction

  // Per-cycle compare against the expectation queue.
  always @(negedge clk) begin
    exp_t e;
    bit   ok;
    if (reset)                  e = mk(0, 0, 0, 0, 0, '0, '0);
    else if (exp_q.size() > 0)  e = exp_q.pop_front();
    else                        e = mk(1, 0, 0, 0, 0, '0, '0);
    if (e.commit) ref_mem[e.addr[4:0]] = e.wdata;
    ok = (ready === e.ready) && (done === e.done) && (mem_rd === e.rd) && (mem_wr === e.wr);
    if (reset) ok = ok && (mem_addr === 32'h0) && (mem_wdata === 32'h0);
    if (e.rd || e.wr) ok = ok && (mem_addr === e.addr);
    if (e.wr) ok = ok && (mem_wdata === e.wdata);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL outputs t=%0t: got ready=%b done=%b rd=%b wr=%b addr=%h wdata=%h, expected ready=%b done=%b rd=%b wr=%b addr=%h wdata=%h",
               $time, ready, done, mem_rd, mem_wr, mem_addr, mem_wdata,
               e.ready, e.done, e.rd, e.wr, e.addr, e.wdata);
    end
  end

  // Bus responder: acks after the wait count chosen when the store was issued.
  int cnt = 0;
  always @(negedge clk) begin
    if (reset || !(mem_rd || mem_wr)) begin
      cnt       = 0;
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom();
    end else begin
      mem_ack = (cnt == (mem_rd ? rd_wait : wr_wait));
      mem_rdata = (mem_ack && mem_rd) ? bus_mem[mem_addr[4:0]] : $urandom();
      if (mem_ack && mem_wr) begin
        bus_mem[mem_addr[4:0]] = mem_wdata;
        wlog.push_back({mem_addr, mem_wdata});
      end
      cnt = mem_ack ? 0 : cnt + 1;
    end
  end

  task automatic junk();
    start    = 1'($urandom_range(0, 1));
    is_byte  = 1'($urandom_range(0, 1));
    addr     = $urandom_range(0, 31);
    wdata    = $urandom();
    byte_idx = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 300; n++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0) begin
        start = 1'b0;
        return;
      end
      junk();
    end
    checks++;
    errors++;
    $display("FAIL wait_ready: got busy after 300 cycles, expected idle");
    exp_q.delete();
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      junk();
      start = 1'b0;
    end
  endtask

  task automatic go(input bit b, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] idx, input int rw, input int ww);
    logic [31:0] wd;
    wait_ready();
    start = 1'b1; is_byte = b; addr = a; wdata = d; byte_idx = idx;
    rd_wait = rw; wr_wait = ww;
    wd = b ? merge(ref_mem[a[4:0]], d[7:0], idx) : d;
    exp_q.push_back(mk(1, 0, 0, 0, 0, '0, '0));
    if (b) repeat (rw + 1) exp_q.push_back(mk(0, 0, 1, 0, 0, a, '0));
    repeat (ww + 1) exp_q.push_back(mk(0, 0, 0, 1, 0, a, wd));
    exp_q.push_back(mk(0, 1, 0, 0, 1, a, wd));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, expv);
    end
  endtask

  task automatic chk_write(input string name, input logic [31:0] a, input logic [31:0] d);
    logic [63:0] w;
    if (wlog.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no bus write, expected %h @ %h", name, d, a);
    end else begin
      w = wlog.pop_back();
      chk({name, "_addr"}, w[63:32], a);
      chk({name, "_data"}, w[31:0], d);
    end
  endtask

  logic [31:0] lane_exp[4] = '{32'hFFFF_FF5A, 32'hFFFF_5AFF, 32'hFF5A_FFFF, 32'h5AFF_FFFF};

  initial begin
    int          n0;
    logic [31:0] d;
    logic [31:0] expw;
    reset = 1'b1; start = 1'b0; is_byte = 1'b0; addr = '0; wdata = '0; byte_idx = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 32; i++) begin
      d = $urandom();
      bus_mem[i] = d;
      ref_mem[i] = d;
    end
    for (int i = 0; i < 4; i++) begin
      bus_mem[i] = 32'hFFFF_FFFF;
      ref_mem[i] = 32'hFFFF_FFFF;
    end
    bus_mem[16] = 32'h1122_3344;
    ref_mem[16] = 32'h1122_3344;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    go(1'b1, 32'h10, 32'h7777_77AB, 2'd1, 0, 0);
    wait_ready();
    chk_write("byte_lane1", 32'h10, 32'h1122_AB44);

    for (int i = 0; i < 4; i++) begin
      go(1'b1, 32'(i), 32'hC3C3_C35A, 2'(i), 0, 0);
      wait_ready();
      chk_write("lane", 32'(i), lane_exp[i]);
    end

    go(1'b0, 32'h5, 32'hDEAD_BEEF, 2'd3, 0, 2);
    wait_ready();
    chk_write("word_wait2", 32'h5, 32'hDEAD_BEEF);

    for (int i = 0; i < 200; i++) begin
      go(1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom(),
         2'($urandom_range(0, 3)), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) begin
        wait_ready();
        idle_cycles($urandom_range(0, 2));
      end
    end
    wait_ready();

    n0 = wlog.size();
    go(1'b1, 32'h7, 32'h0000_0099, 2'd2, 20, 0);
    repeat (3) begin
      @(posedge clk); #1;
      junk();
    end
    reset = 1'b1;
    exp_q.delete();
    junk();
    @(posedge clk); #1;
    junk();
    @(posedge clk); #1;
    reset = 1'b0;
    start = 1'b0;
    idle_cycles(2);
    chk("reset_no_write", 32'(wlog.size()), 32'(n0));

    expw = merge(ref_mem[7], 8'h66, 2'd0);
    go(1'b1, 32'h7, 32'hFFFF_FF66, 2'd0, 1, 1);
    wait_ready();
    chk_write("after_reset", 32'h7, expw);

    for (int i = 0; i < 32; i++) chk("memory", bus_mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion by %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/store_rmw.md
Name: store_rmw

Overview:
- Store sequencer for the CPU2 datapath.
- Sits directly downstream of the execute-stage byte-insert logic and turns store requests into memory bus cycles.
- Word stores go straight to memory as a single write.
- Byte stores run a read-modify-write: read the addressed word, insert the byte at the lane given by byte_idx, write the merged word back.
- Holds the CPU pipeline via `ready` until the store completes.

Parameters:
- WIDTH, 32, data word width; must be 32 (byte lanes fixed at 4).
- AW, 32, address width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  store request; sampled only while ready=1.
- is_byte  input  1  1 = byte store (RMW), 0 = full word store.
- addr  input  AW  word address of the store.
- wdata  input  WIDTH  store data; byte stores use wdata[7:0] only.
- byte_idx  input  2  byte lane for byte stores; 0 = bits 7:0 … 3 = bits 31:24.
- ready  output  1  1 = idle and able to accept start.
- done  output  1  one-cycle pulse when the store has completed.
- mem_addr  output  AW  bus address.
- mem_rd  output  1  bus read request.
- mem_wr  output  1  bus write request.
- mem_wdata  output  WIDTH  bus write data.
- mem_rdata  input  WIDTH  bus read data; valid in the cycle mem_ack=1 during a read.
- mem_ack  input  1  bus completion; may be high in the same cycle the request is first asserted.

Behaviour:
- Reset (synchronous, active-high):
  - State goes to IDLE; all latched operands clear to 0.
  - In the cycle reset is high and on the following edge: ready=0, done=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_wdata=0.
  - First cycle after reset deasserts: ready=1.
- State machine (registered state, outputs decoded from state and latched regs): IDLE, RD, WR, DONE.
- IDLE:
  - ready=1; no bus request.
  - start=1 latches addr, wdata, byte_idx, is_byte.
  - Next state is RD if is_byte=1, else WR.
- RD:
  - mem_rd=1, mem_addr=latched addr, ready=0.
  - Holds while mem_ack=0.
  - On mem_ack=1: capture merged word into wbuf, go to WR.
  - Merge keeps mem_rdata in all lanes except lane byte_idx, which takes latched wdata[7:0].
  - Example, byte_idx=2: {rd[31:24], b, rd[15:0]}.
- WR:
  - mem_wr=1, mem_addr=latched addr, ready=0.
  - mem_wdata = wbuf for byte stores; latched wdata for word stores.
  - Holds while mem_ack=0; on mem_ack=1 go to DONE.
- DONE:
  - done=1 for exactly one cycle, ready=0; next state IDLE.
- Bus rules:
  - mem_rd and mem_wr are never high together.
  - Request signals and mem_addr/mem_wdata stay stable from first assertion until the cycle mem_ack=1.
- Latency with zero-wait bus (ack in first request cycle), start accepted at edge T:
  - Byte store: RD in T+1, WR in T+2, done in T+3, ready again in T+4.
  - Word store: WR in T+1, done in T+2, ready again in T+3.
  - Each wait cycle (ack low) adds one cycle.
- start while ready=0 is ignored; no queuing. Operands are latched only in IDLE, so input changes mid-operation have no effect.
- mem_ack while in IDLE or DONE is ignored.
- reset mid-operation: request drops at the reset edge, no write is issued, done is not pulsed, state returns to IDLE.
- byte_idx is ignored for word stores; wdata[31:8] is ignored for byte stores.
- Back-to-back: a new start is accepted only in the cycle after DONE (ready=1 again). Minimum issue spacing is 4 cycles for byte stores, 3 for word stores.

Test Plan:
- Reset release → ready=1 one cycle after reset falls, all bus outputs 0, done=0.
- Byte store, zero-wait bus: addr=0x10, wdata=0xAB, byte_idx=1, memory word 0x11223344.
  - mem_rd at T+1, then mem_wr at T+2 with mem_wdata=0x1122AB44.
  - done pulse at T+3, ready=1 at T+4.
- All four lanes: wdata=0x5A, memory 0xFFFFFFFF, byte_idx=0..3.
  - Write data 0xFFFFFF5A, 0xFFFF5AFF, 0xFF5AFFFF, 0x5AFFFFFF respectively.
- Word store with 2-cycle ack delay: wdata=0xDEADBEEF.
  - No mem_rd ever asserted; mem_wr held 3 cycles with stable addr/data.
  - done one cycle after the ack.
- start pulses while busy, and inputs toggled mid-store → ignored; only the original store is written; exactly one done pulse.
- reset asserted during RD with ack held low → mem_rd drops at the reset edge, no mem_wr, no done, ready=1 one cycle after reset deasserts.
